// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel selector.
package scan_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 word multiplexer; an out-of-range select yields zero.
module mux_nto1 #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 8,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS*WIDTH-1:0] i_din,
   input  logic [SEL_W-1:0]          i_sel,
   output logic [WIDTH-1:0]          o_dout
);

   logic [WIDTH-1:0] w_words [CHANNELS];

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_word
         assign w_words[gi] = i_din[gi*WIDTH +: WIDTH];
      end
   endgenerate

   always_comb begin
      o_dout = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (i_sel == SEL_W'(k)) o_dout = w_words[k];
      end
   end

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 word selector with manual select and an auto-scan mode that
// dwells DWELL cycles per channel and emits one valid sample per channel.
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 8,
   parameter  int DWELL    = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic                      en,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          dout,
   output logic [SEL_W-1:0]          ch,
   output logic                      valid,
   output logic                      wrap,
   output logic                      err
);

   localparam int                 CNT_W    = $clog2(DWELL) + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(CHANNELS - 1);
   localparam logic [SEL_W:0]     CH_LIMIT = (SEL_W + 1)'(CHANNELS);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [SEL_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_dout;
   logic [SEL_W-1:0] r_ch;
   logic             r_valid;
   logic             r_wrap;
   logic             r_err;
   logic             w_sel_ok;
   logic             w_scan_entry;
   logic [SEL_W-1:0] w_mux_sel;
   logic [WIDTH-1:0] w_mux_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = ST_IDLE;
      if (en) w_state_next = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
   end

   assign w_sel_ok     = ({1'b0, sel} < CH_LIMIT);
   assign w_scan_entry = (w_state_next == ST_SCAN) && (r_state != ST_SCAN);
   // Select follows the state being entered so a mid-dwell switch to MANUAL captures din[sel].
   assign w_mux_sel    = (w_state_next == ST_SCAN) ? r_ptr : sel;

   mux_nto1 #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_mux (
      .i_din  (din),
      .i_sel  (w_mux_sel),
      .o_dout (w_mux_dout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout  <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
         case (w_state_next)
            ST_MANUAL: begin
               if (w_sel_ok) begin
                  r_dout  <= w_mux_dout;
                  r_ch    <= sel;
                  r_valid <= 1'b1;
               end else begin
                  r_err   <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (w_scan_entry) begin
                  r_ptr <= '0;
                  r_cnt <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_dout  <= w_mux_dout;
                  r_ch    <= r_ptr;
                  r_valid <= 1'b1;
                  r_wrap  <= (r_ptr == LAST_CH);
                  r_cnt   <= '0;
                  r_ptr   <= (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = r_dout;
   assign ch    = r_ch;
   assign valid = r_valid;
   assign wrap  = r_wrap;
   assign err   = r_err;

endmodule
